data_mem_responder: RTL and testbench

Multi-cycle data-memory responder that services load/store requests issued by the processor's MEM stage over a valid/ready request channel and returns results on a valid/ready response channel. It holds a word-organised RAM, inserts a configurable number of wait states, and performs byte/halfword/word lane selection with sign or zero extension on loads. It sits between the processor's memory-access stage and the backing storage, replacing the single-cycle data memory where stalls must be modelled.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/dmem_lane_align.sv | 44 ++++
 rtl/data_mem_responder.sv | 152 +++++++++++++++
 tb/tb_data_mem_responder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: size encodings, FSM states, captured request.
package dmem_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic              we;
    size_e             size;
    logic              uns;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Halfwords must sit on even bytes, words on multiples of four.
  function automatic logic misaligned(input size_e size, input logic [1:0] lo);
    return (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane select/extend for loads and lane merge for stores (pure combinational).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [1:0]  lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_c,
  output logic [31:0] merged_c
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = word[{lo, 3'b000} +: 8];
  assign sel_half = lo[1] ? word[31:16] : word[15:0];

  // Halfword lane is chosen by lo[1] only; lo[0] is an alignment concern of the caller.
  always_comb begin
    load_c   = '0;
    merged_c = word;
    unique case (size)
      SZ_BYTE: begin
        load_c = uns ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
        merged_c[{lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_c = uns ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
        merged_c[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SZ_WORD: begin
        load_c   = word;
        merged_c = wdata;
      end
      default: begin
        load_c   = '0;
        merged_c = word;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder with configurable wait states and byte/half/word lanes.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned halfword/word accesses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  req_t               cap;
  logic [ADDR_W-1:0]  cap_addr;
  logic               ready_reg;
  logic               valid_reg;
  logic [31:0]        rdata_reg;
  logic               err_reg;

  logic [31:0]        mem [DEPTH];

  req_t               acc;
  logic [ADDR_W-1:0]  acc_addr;
  logic [ADDR_W-3:0]  word_addr;
  logic [IDX_W-1:0]   acc_idx;
  logic               oob;
  logic               align_err;
  logic               acc_err;
  logic               accept;
  logic               do_access;
  logic               mem_we;
  logic [31:0]        stored;
  logic [31:0]        load_c;
  logic [31:0]        merged_c;
  logic [31:0]        acc_rdata;

  assign bus.req_ready = ready_reg;
  assign bus.rsp_valid = valid_reg;
  assign bus.rsp_rdata = rdata_reg;
  assign bus.rsp_err   = err_reg;

  assign accept = (state == IDLE) && bus.req_valid && ready_reg;

  // With zero wait states the access uses the request straight off the bus.
  always_comb begin
    acc      = cap;
    acc_addr = cap_addr;
    if (state == IDLE) begin
      acc.we    = bus.req_we;
      acc.size  = size_e'(bus.req_size);
      acc.uns   = bus.req_unsigned;
      acc.wdata = bus.req_wdata;
      acc_addr  = bus.req_addr;
    end
  end

  assign word_addr = acc_addr[ADDR_W-1:2];
  assign oob       = word_addr >= (ADDR_W-2)'(DEPTH);
  assign acc_idx   = word_addr[IDX_W-1:0];
  assign stored    = mem[acc_idx];

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = misaligned(acc.size, acc_addr[1:0]);
`else
  assign align_err = 1'b0;
`endif

  assign acc_err   = (acc.size == SZ_RSVD) || oob || align_err;
  assign acc_rdata = (acc.we || acc_err) ? 32'd0 : load_c;

  assign do_access = (WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (cnt == '0));
  assign mem_we    = do_access && acc.we && !acc_err && !rst;

  dmem_lane_align u_lane_align (
    .size     (acc.size),
    .uns      (acc.uns),
    .lo       (acc_addr[1:0]),
    .word     (stored),
    .wdata    (acc.wdata),
    .load_c   (load_c),
    .merged_c (merged_c)
  );

  // RAM is never cleared; a store colliding with reset is dropped via mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= merged_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      cap_addr  <= '0;
      ready_reg <= 1'b0;
      valid_reg <= 1'b0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready_reg <= 1'b1;
          if (accept) begin
            cap       <= acc;
            cap_addr  <= acc_addr;
            ready_reg <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              valid_reg <= 1'b1;
              rdata_reg <= acc_rdata;
              err_reg   <= acc_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            valid_reg <= 1'b1;
            rdata_reg <= acc_rdata;
            err_reg   <= acc_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state     <= IDLE;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus randomized traffic vs a byte-lane model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH       = 256;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned WAIT_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ref_mem [DEPTH];

  data_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_responder #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: little-endian lanes computed with masks and shifts on a word array.
  function automatic void model(input bit we, input bit [1:0] sz, input bit uns,
                                input bit [31:0] addr, input bit [31:0] wd,
                                output bit [31:0] rd, output bit err);
    int unsigned nb, off;
    longint unsigned mask, word, val;
    rd  = 32'd0;
    err = (sz == 2'd3) || ((addr / 4) >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    if (sz == 2'd1 && (addr % 2) != 0) err = 1'b1;
    if (sz == 2'd2 && (addr % 4) != 0) err = 1'b1;
`endif
    if (err) return;
    nb   = 1 << sz;
    off  = ((addr % 4) / nb) * nb;
    mask = (64'd1 << (8 * nb)) - 1;
    word = 64'(ref_mem[addr / 4]);
    if (we) begin
      word = (word & ~(mask << (8 * off))) | ((64'(wd) & mask) << (8 * off));
      ref_mem[addr / 4] = word[31:0];
    end else begin
      val = (word >> (8 * off)) & mask;
      if (!uns && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
      rd = val[31:0];
    end
  endfunction

  task automatic drive_req(input bit we, input bit [1:0] sz, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
  endtask

  // One full transaction: accept, latency, response contents, optional back-pressure, release.
  task automatic txn(input bit we, input bit [1:0] sz, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er);
    bit [31:0]   erd;
    bit          eerr;
    int          n;
    logic [31:0] rd0;
    logic        er0;
    model(we, sz, uns, addr, wd, erd, eerr);
    wait_ready();
    drive_req(we, sz, uns, addr, wd);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1; n++;
    end
    chk("latency", 32'(n), 32'(WAIT_CYCLES + 1));
    rd0 = bus.rsp_rdata;
    er0 = bus.rsp_err;
    chk("rsp_rdata", rd0, erd);
    chk("rsp_err", 32'(er0), 32'(eerr));
    chk("req_ready_resp", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      drive_req($urandom_range(0, 1), 2'($urandom_range(0, 2)), 1'b0, $urandom_range(0, 63), $urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, rd0);
      chk("hold_err", 32'(bus.rsp_err), 32'(er0));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_req_ready", 32'(bus.req_ready), 32'd1);
    rd = rd0;
    er = er0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] saved;
    bit          we;
    bit [1:0]    sz;
    logic [31:0] addr;

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_ready", 32'(bus.req_ready), 32'd1);

    // Give the first 16 words known contents.
    for (int i = 0; i < 16; i++) txn(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0, rd, er);

    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, rd, er);
    chk("lw_deadbeef", rd, 32'hDEADBEEF);
    chk("lw_deadbeef_err", 32'(er), 32'd0);

    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 0, rd, er);
    txn(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 0, rd, er);
    chk("sb_rdata_zero", rd, 32'd0);
    txn(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 0, rd, er);
    chk("lb_signed", rd, 32'hFFFFFF80);
    txn(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 0, rd, er);
    chk("lbu", rd, 32'h00000080);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, rd, er);
    chk("lw_after_sb", rd, 32'h80223344);

    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'h80017FFF, 0, rd, er);
    txn(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 0, rd, er);
    chk("lh_hi_signed", rd, 32'hFFFF8001);
    txn(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, 0, rd, er);
    chk("lh_lo_signed", rd, 32'h00007FFF);

    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5, rd, er);
    chk("hold_lw", rd, 32'h80017FFF);

    saved = ref_mem[0];
    txn(1'b1, 2'd2, 1'b0, 32'h400, 32'hA5A5A5A5, 0, rd, er);
    chk("oob_err", 32'(er), 32'd1);
    chk("oob_rdata", rd, 32'd0);
    txn(1'b0, 2'd2, 1'b0, 32'h0, 32'd0, 0, rd, er);
    chk("oob_word0_intact", rd, saved);
    txn(1'b0, 2'd3, 1'b0, 32'h4, 32'd0, 0, rd, er);
    chk("rsvd_size_err", 32'(er), 32'd1);

    txn(1'b1, 2'd2, 1'b0, 32'h11, 32'h55AA55AA, 0, rd, er);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misaligned_lw_unchanged", rd, 32'h80017FFF);
`else
    chk("misaligned_lw_whole_word", rd, 32'h55AA55AA);
`endif

    // Reset lands on the cycle the store would commit; the word must survive.
    saved = ref_mem[5];
    wait_ready();
    drive_req(1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFEF00D);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle_ready", 32'(bus.req_ready), 32'd1);
    txn(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, 0, rd, er);
    chk("abort_word_intact", rd, saved);

    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 63));
      txn(we, sz, 1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 2), rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
